// File: rtl/mvm_pkg.sv
// Shared types and default sizing for the matrix-vector operand sequencer and its MAC stage.
package mvm_pkg;

    localparam int MVM_W = 10;
    localparam int MVM_M = 4;
    localparam int MVM_N = 4;

    typedef logic signed [MVM_W-1:0] operand_t;

    typedef enum logic [1:0] {
        LOAD_M,
        LOAD_X,
        COMPUTE
    } state_t;

    // Width of a counter/address covering n values, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvm_operand_mem.sv
// DEPTH x W register array with one write port and one registered read port.
module mvm_operand_mem
    import mvm_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 10,
    localparam int AW   = clog2_min1(DEPTH)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic signed [W-1:0] wr_data,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    output logic signed [W-1:0] rd_data
);

    logic signed [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mvm_operand_sequencer.sv
// Loads an M x N matrix and N-vector from one stream, then issues (a, b) pairs row by row to the MAC.
module mvm_operand_sequencer
    import mvm_pkg::*;
#(
    parameter int M = MVM_M,
    parameter int N = MVM_N,
    parameter int W = MVM_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic signed [W-1:0] m_a,
    output logic signed [W-1:0] m_b,
    output logic                m_valid,
    output logic                m_first,
    output logic                m_last,
    output logic                busy
);

    localparam int RW  = clog2_min1(M);
    localparam int CW  = clog2_min1(N);
    localparam int MAW = clog2_min1(M * N);

    state_t              state;
    logic [RW-1:0]       row;
    logic [CW-1:0]       col;
    logic                issuing;
    logic                v1, first1, last1, fin1, fin2;
    logic                xfer, row_end, col_end, rd_en;
    logic [MAW-1:0]      mat_addr;
    logic signed [W-1:0] mat_rd, vec_rd;

    assign xfer     = s_valid && s_ready;
    assign row_end  = (row == RW'(M - 1));
    assign col_end  = (col == CW'(N - 1));
    assign rd_en    = (state == COMPUTE) && issuing;
    assign mat_addr = MAW'(row) * MAW'(N) + MAW'(col);

    mvm_operand_mem #(.DEPTH(M * N), .W(W)) u_matrix (
        .clk     (clk),
        .wr_en   (xfer && (state == LOAD_M)),
        .wr_addr (mat_addr),
        .wr_data (s_data),
        .rd_en   (rd_en),
        .rd_addr (mat_addr),
        .rd_data (mat_rd)
    );

    mvm_operand_mem #(.DEPTH(N), .W(W)) u_vector (
        .clk     (clk),
        .wr_en   (xfer && (state == LOAD_X)),
        .wr_addr (col),
        .wr_data (s_data),
        .rd_en   (rd_en),
        .rd_addr (col),
        .rd_data (vec_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LOAD_M;
            row     <= '0;
            col     <= '0;
            issuing <= 1'b0;
            v1      <= 1'b0;
            first1  <= 1'b0;
            last1   <= 1'b0;
            fin1    <= 1'b0;
            fin2    <= 1'b0;
            s_ready <= 1'b0;
            m_a     <= '0;
            m_b     <= '0;
            m_valid <= 1'b0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            // Marker pipeline runs alongside the one-cycle memory read.
            v1      <= rd_en;
            first1  <= rd_en && (col == '0);
            last1   <= rd_en && col_end;
            fin1    <= rd_en && row_end && col_end;
            fin2    <= fin1;
            m_valid <= v1;
            m_first <= v1 && first1;
            m_last  <= v1 && last1;
            if (v1) begin
                m_a <= mat_rd;
                m_b <= vec_rd;
            end

            case (state)
                LOAD_M: begin
                    s_ready <= 1'b1;
                    if (xfer) begin
                        if (col_end) begin
                            col <= '0;
                            if (row_end) begin
                                row   <= '0;
                                state <= LOAD_X;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                LOAD_X: begin
                    s_ready <= 1'b1;
                    if (xfer) begin
                        if (col_end) begin
                            col     <= '0;
                            state   <= COMPUTE;
                            s_ready <= 1'b0;
                            busy    <= 1'b1;
                            issuing <= 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    s_ready <= 1'b0;
                    if (issuing) begin
                        if (col_end) begin
                            col <= '0;
                            if (row_end) begin
                                row     <= '0;
                                issuing <= 1'b0;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                    // Stay busy until the final pair has left the output register.
                    if (fin2) begin
                        state   <= LOAD_M;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: state <= LOAD_M;
            endcase
        end
    end

endmodule
